mem_bus_arbiter: RTL and testbench

- Shares one external memory bus between the CPU's instruction-fetch port and data load/store port.
- Sequences each access as a registered bus transaction that honours waitrequest, and returns a one-cycle ready pulse with registered read data.
- Sits between the CPU core and the bus-based memory, letting the Harvard-style core run on a single bus.
- Optional watchdog aborts transactions stuck on waitrequest.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU's fetch/data ports, the shared memory bus and the arbiter.
// The arbiter connects through the master modport; the CPU/memory side uses the slave modport.
interface mem_bus_arbiter_if;
    logic        clk_enable;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_ready;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_ready;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        err;

    modport master (
        input  clk_enable,
        input  i_read, i_address,
        output i_readdata, i_ready,
        input  d_read, d_write, d_address, d_writedata, d_byteenable,
        output d_readdata, d_ready,
        output bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
        input  bus_waitrequest, bus_readdata,
        output err
    );

    modport slave (
        output clk_enable,
        output i_read, i_address,
        input  i_readdata, i_ready,
        output d_read, d_write, d_address, d_writedata, d_byteenable,
        input  d_readdata, d_ready,
        input  bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
        output bus_waitrequest, bus_readdata,
        input  err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction-fetch and data ports with an optional stall watchdog.
// Define ARB_ROUND_ROBIN_EN to replace fixed data-over-fetch priority with round-robin arbitration.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master mif
);
    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;            // 1 = data port owns the bus
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_rdy_q, i_rdy_d;
    logic        d_rdy_q, d_rdy_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        d_req;
    logic        grant_d;
    logic        done;
    logic        abort;
    logic [31:0] rdata_v;

    assign d_req = mif.d_read | mif.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;                 // 1 = data port was granted last

    assign grant_d = d_req && !(mif.i_read && last_d_q);

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == RESP) begin
            last_d_d = owner_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_q <= 1'b1;
        end else if (mif.clk_enable) begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_rdy_d   = 1'b0;
        d_rdy_d   = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        abort     = 1'b0;
        rdata_v   = '0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUS_D;
                    owner_d = 1'b1;
                    addr_d  = {mif.d_address[31:2], 2'b00};
                    be_d    = mif.d_byteenable;
                    cnt_d   = '0;
                    // A simultaneous read+write request is treated as a write only
                    if (mif.d_write) begin
                        wr_d    = 1'b1;
                        wdata_d = mif.d_writedata;
                    end else begin
                        rd_d    = 1'b1;
                    end
                end else if (mif.i_read) begin
                    state_d = BUS_I;
                    owner_d = 1'b0;
                    addr_d  = {mif.i_address[31:2], 2'b00};
                    be_d    = 4'b1111;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUS_I, BUS_D: begin
                if (!mif.bus_waitrequest) begin
                    done = 1'b1;
                end else if (WD_EN && (cnt_q == TO_LAST)) begin
                    done  = 1'b1;
                    abort = 1'b1;
                end else if (cnt_q != TO_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (done) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = RESP;
                    rdata_v = (rd_q && !abort) ? mif.bus_readdata : 32'h0;
                    if (abort) begin
                        err_d = 1'b1;
                    end
                    if (owner_q) begin
                        d_rdy_d   = 1'b1;
                        d_rdata_d = rdata_v;
                    end else begin
                        i_rdy_d   = 1'b1;
                        i_rdata_d = rdata_v;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clk_enable low freezes every register, so a stall release while frozen is never seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (mif.clk_enable) begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_rdy_q   <= i_rdy_d;
            d_rdy_q   <= d_rdy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mif.bus_address    = addr_q;
    assign mif.bus_read       = rd_q;
    assign mif.bus_write      = wr_q;
    assign mif.bus_writedata  = wdata_q;
    assign mif.bus_byteenable = be_q;
    assign mif.i_readdata     = i_rdata_q;
    assign mif.i_ready        = i_rdy_q;
    assign mif.d_readdata     = d_rdata_q;
    assign mif.d_ready        = d_rdy_q;
    assign mif.err            = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model of the arbitration rules.
// Build with ARB_ROUND_ROBIN_EN defined to exercise round-robin arbitration in both DUT and model.
module tb_mem_bus_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if mif();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the bus side: what the last grant left on the bus, sticky error, last grantee
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic        m_err;
    logic        m_last_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr   = '0;
        m_wd     = '0;
        m_be     = '0;
        m_err    = 1'b0;
        m_last_d = 1'b1;
    endtask

    task automatic check_bus(input string tag, input logic rd, input logic wr);
        check({tag, ".bus_read"},  {31'b0, mif.bus_read},  {31'b0, rd});
        check({tag, ".bus_write"}, {31'b0, mif.bus_write}, {31'b0, wr});
        check({tag, ".bus_addr"},  mif.bus_address, m_addr);
        check({tag, ".bus_wdata"}, mif.bus_writedata, m_wd);
        check({tag, ".bus_be"},    {28'b0, mif.bus_byteenable}, {28'b0, m_be});
        check({tag, ".i_ready"},   {31'b0, mif.i_ready}, 32'h0);
        check({tag, ".d_ready"},   {31'b0, mif.d_ready}, 32'h0);
        check({tag, ".err"},       {31'b0, mif.err}, {31'b0, m_err});
    endtask

    task automatic check_resp(input string tag, input logic own_d, input logic is_rd,
                              input logic [31:0] rdata);
        check({tag, ".bus_read"},  {31'b0, mif.bus_read},  32'h0);
        check({tag, ".bus_write"}, {31'b0, mif.bus_write}, 32'h0);
        check({tag, ".bus_addr"},  mif.bus_address, m_addr);
        check({tag, ".i_ready"},   {31'b0, mif.i_ready}, {31'b0, !own_d});
        check({tag, ".d_ready"},   {31'b0, mif.d_ready}, {31'b0, own_d});
        check({tag, ".err"},       {31'b0, mif.err}, {31'b0, m_err});
        if (is_rd) begin
            if (own_d) check({tag, ".d_rdata"}, mif.d_readdata, rdata);
            else       check({tag, ".i_rdata"}, mif.i_readdata, rdata);
        end
    endtask

    // Serve one request (or one idle cycle) starting from an IDLE cycle; stalls<0 = random
    task automatic serve_one(input string tag, input int stalls);
        logic        pend_i, pend_d, own_d, exp_rd, exp_wr;
        logic [31:0] rdata;
        int          n_st;
        pend_i = mif.i_read;
        pend_d = mif.d_read | mif.d_write;
        if (!pend_i && !pend_d) begin
            mif.bus_waitrequest = 1'($urandom_range(0, 1));
            tick();
            check_bus({tag, ".idle"}, 1'b0, 1'b0);
            return;
        end
`ifdef ARB_ROUND_ROBIN_EN
        own_d = pend_d && !(pend_i && m_last_d);
`else
        own_d = pend_d;
`endif
        if (own_d) begin
            m_addr = mif.d_address & 32'hFFFF_FFFC;
            m_be   = mif.d_byteenable;
            exp_wr = mif.d_write;
            exp_rd = !mif.d_write;
            if (exp_wr) m_wd = mif.d_writedata;
        end else begin
            m_addr = mif.i_address & 32'hFFFF_FFFC;
            m_be   = 4'hF;
            exp_wr = 1'b0;
            exp_rd = 1'b1;
        end
        tick();
        check_bus({tag, ".grant"}, exp_rd, exp_wr);
        if ($urandom_range(0, 3) == 0) begin
            if (own_d) begin mif.d_read = 1'b0; mif.d_write = 1'b0; end
            else       mif.i_read = 1'b0;
        end
        n_st = (stalls < 0) ? int'($urandom_range(0, 4)) : stalls;
        for (int s = 0; s < n_st; s++) begin
            mif.bus_waitrequest = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                mif.clk_enable      = 1'b0;
                mif.bus_waitrequest = 1'b0;
                mif.bus_readdata    = $urandom;
                tick();
                check_bus({tag, ".frozen"}, exp_rd, exp_wr);
                mif.clk_enable      = 1'b1;
                mif.bus_waitrequest = 1'b1;
            end
            tick();
            check_bus({tag, ".stall"}, exp_rd, exp_wr);
        end
        rdata = $urandom;
        mif.bus_waitrequest = 1'b0;
        mif.bus_readdata    = rdata;
        tick();
        check_resp({tag, ".resp"}, own_d, exp_rd, rdata);
        $display("txn %s: port=%s %s addr=%h stalls=%0d", tag, own_d ? "D" : "I",
                 exp_wr ? "WR" : "RD", m_addr, n_st);
        m_last_d = own_d;
        if (own_d) begin mif.d_read = 1'b0; mif.d_write = 1'b0; end
        else       mif.i_read = 1'b0;
        mif.bus_waitrequest = 1'($urandom_range(0, 1));
        mif.bus_readdata    = $urandom;
        tick();
        check_bus({tag, ".after"}, 1'b0, 1'b0);
    endtask

    task automatic rand_requests();
        int k;
        if (!mif.i_read && $urandom_range(0, 1) == 1) begin
            mif.i_read    = 1'b1;
            mif.i_address = $urandom;
        end
        if (!(mif.d_read || mif.d_write) && $urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, 2));
            mif.d_read       = (k != 1);
            mif.d_write      = (k != 0);
            mif.d_address    = $urandom;
            mif.d_writedata  = $urandom;
            mif.d_byteenable = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        mif.clk_enable      = 1'b1;
        mif.i_read          = 1'b0;
        mif.i_address       = '0;
        mif.d_read          = 1'b0;
        mif.d_write         = 1'b0;
        mif.d_address       = '0;
        mif.d_writedata     = '0;
        mif.d_byteenable    = '0;
        mif.bus_waitrequest = 1'b0;
        mif.bus_readdata    = '0;
        model_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_bus("reset", 1'b0, 1'b0);
        check("reset.i_rdata", mif.i_readdata, 32'h0);
        check("reset.d_rdata", mif.d_readdata, 32'h0);

        // Single fetch, unaligned address
        mif.i_read    = 1'b1;
        mif.i_address = 32'hBFC0_0002;
        serve_one("fetch", 0);

        // Store with three stall cycles
        mif.d_write      = 1'b1;
        mif.d_address    = 32'h0000_1004;
        mif.d_writedata  = 32'hDEAD_BEEF;
        mif.d_byteenable = 4'b0011;
        serve_one("store", 3);

        // Simultaneous fetch and load
        mif.i_read       = 1'b1;
        mif.i_address    = 32'h0000_0100;
        mif.d_read       = 1'b1;
        mif.d_address    = 32'h0000_2008;
        mif.d_byteenable = 4'hF;
        serve_one("both.a", 0);
        serve_one("both.b", 0);

        for (int it = 0; it < 300; it++) begin
            rand_requests();
            serve_one($sformatf("rnd%0d", it), -1);
        end

        // Reset while a stalled store is on the bus
        mif.i_read = 1'b0;
        mif.d_read = 1'b0;
        while (mif.bus_read || mif.bus_write) tick();
        mif.d_write     = 1'b1;
        mif.d_address   = 32'h0000_3000;
        mif.d_writedata = 32'h1234_5678;
        mif.bus_waitrequest = 1'b1;
        tick();
        check("rst_mid.pre_write", {31'b0, mif.bus_write}, 32'h1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_bus("rst_mid", 1'b0, 1'b0);
        mif.d_write = 1'b0;
        mif.bus_waitrequest = 1'b0;
        tick();
        reset = 1'b0;
        check_bus("rst_mid.hold", 1'b0, 1'b0);
        tick();
        check_bus("rst_mid.idle", 1'b0, 1'b0);

        // Watchdog: load that never sees waitrequest drop
        mif.d_read       = 1'b1;
        mif.d_address    = 32'h0000_4444;
        mif.d_byteenable = 4'b1100;
        mif.bus_waitrequest = 1'b1;
        mif.bus_readdata    = 32'hFFFF_FFFF;
        m_addr = 32'h0000_4444;
        m_be   = 4'b1100;
        tick();
        check_bus("wd.grant", 1'b1, 1'b0);
        for (int s = 1; s < TO; s++) begin
            tick();
            check_bus($sformatf("wd.stall%0d", s), 1'b1, 1'b0);
        end
        tick();
        m_err = 1'b1;
        check_resp("wd.abort", 1'b1, 1'b1, 32'h0);
        $display("txn wd: port=D RD addr=%h aborted err=%0b", m_addr, mif.err);
        m_last_d = 1'b1;
        mif.d_read = 1'b0;
        tick();
        check_bus("wd.after", 1'b0, 1'b0);
        tick();
        check_bus("wd.sticky", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
